id_dual_issue: RTL

ID-stage consumer of the IF/ID pipeline register pair. Each cycle it takes the registered two-instruction bundle and its PC+8 value, classifies each slot as even-pipe or odd-pipe, and checks an intra-pair dependency. It dual-issues when legal; otherwise it serialises the pair over two cycles and back-pressures fetch. Outputs are registered and drive the even/odd register-fetch stages.

---
 rtl/id_dual_issue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/id_dual_issue.sv
// ID-stage dual-issue steering: classifies the IF/ID pair into even/odd pipes, splits dependent or misordered pairs.
// Optional build macro ISSUE_PERF_CNT_EN adds saturating dual/split event counters.
module id_dual_issue #(
  parameter int PCbitsize = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PCbitsize-1:0] PC_plusEight,
  input  logic [31:0]          first_instruction,
  input  logic [31:0]          second_instruction,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic [31:0]          even_inst,
  output logic [PCbitsize-1:0] even_pc,
  output logic                 even_valid,
  output logic [31:0]          odd_inst,
  output logic [PCbitsize-1:0] odd_pc,
  output logic                 odd_valid,
  output logic [15:0]          dual_count,
  output logic [15:0]          split_count
);

  typedef enum logic {ISSUE, HOLD} state_t;

  state_t               state_reg;
  logic [31:0]          even_inst_reg, odd_inst_reg, held_inst_reg;
  logic [PCbitsize-1:0] even_pc_reg, odd_pc_reg, held_pc_reg;
  logic                 even_valid_reg, odd_valid_reg;

  logic                 s0_nop, s1_nop, s0_odd, s1_odd, held_odd;
  logic                 dep, dual_ok, split_needed, any_live;
  logic [PCbitsize-1:0] pc0, pc1, single_pc;
  logic [31:0]          single_inst;
  logic                 single_odd;

  always_comb begin
    s0_nop   = (first_instruction == 32'h0);
    s1_nop   = (second_instruction == 32'h0);
    s0_odd   = (first_instruction[31:29] == 3'b001);
    s1_odd   = (second_instruction[31:29] == 3'b001);
    held_odd = (held_inst_reg[31:29] == 3'b001);
    pc0      = PC_plusEight - PCbitsize'(8);
    pc1      = PC_plusEight - PCbitsize'(4);
    dep      = !s0_nop && !s1_nop &&
               ((second_instruction[13:7]  == first_instruction[6:0]) ||
                (second_instruction[20:14] == first_instruction[6:0]));
    dual_ok      = !s0_nop && !s1_nop && !s0_odd && s1_odd && !dep;
    split_needed = in_valid && !s0_nop && !s1_nop && !dual_ok;
    any_live     = in_valid && !(s0_nop && s1_nop);
    // When slot0 is live it is always the one issued alone (single or first half of a split).
    single_inst  = s0_nop ? second_instruction : first_instruction;
    single_pc    = s0_nop ? pc1 : pc0;
    single_odd   = s0_nop ? s1_odd : s0_odd;
  end

  always_comb begin
    in_ready = 1'b0;
    if (reset)
      in_ready = 1'b0;
    else if (flush)
      in_ready = 1'b1;
    else if (!stall_in)
      in_ready = (state_reg == ISSUE) ? !split_needed : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ISSUE;
      even_inst_reg  <= '0;
      odd_inst_reg   <= '0;
      held_inst_reg  <= '0;
      even_pc_reg    <= '0;
      odd_pc_reg     <= '0;
      held_pc_reg    <= '0;
      even_valid_reg <= 1'b0;
      odd_valid_reg  <= 1'b0;
    end else if (flush) begin
      state_reg      <= ISSUE;
      even_valid_reg <= 1'b0;
      odd_valid_reg  <= 1'b0;
    end else if (!stall_in) begin
      even_valid_reg <= 1'b0;
      odd_valid_reg  <= 1'b0;
      case (state_reg)
        ISSUE: begin
          if (any_live) begin
            if (dual_ok) begin
              even_inst_reg  <= first_instruction;
              even_pc_reg    <= pc0;
              even_valid_reg <= 1'b1;
              odd_inst_reg   <= second_instruction;
              odd_pc_reg     <= pc1;
              odd_valid_reg  <= 1'b1;
            end else if (single_odd) begin
              odd_inst_reg   <= single_inst;
              odd_pc_reg     <= single_pc;
              odd_valid_reg  <= 1'b1;
            end else begin
              even_inst_reg  <= single_inst;
              even_pc_reg    <= single_pc;
              even_valid_reg <= 1'b1;
            end
            if (split_needed) begin
              held_inst_reg <= second_instruction;
              held_pc_reg   <= pc1;
              state_reg     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (held_odd) begin
            odd_inst_reg   <= held_inst_reg;
            odd_pc_reg     <= held_pc_reg;
            odd_valid_reg  <= 1'b1;
          end else begin
            even_inst_reg  <= held_inst_reg;
            even_pc_reg    <= held_pc_reg;
            even_valid_reg <= 1'b1;
          end
          state_reg <= ISSUE;
        end
        default: state_reg <= ISSUE;
      endcase
    end
  end

  assign even_inst  = even_inst_reg;
  assign even_pc    = even_pc_reg;
  assign even_valid = even_valid_reg;
  assign odd_inst   = odd_inst_reg;
  assign odd_pc     = odd_pc_reg;
  assign odd_valid  = odd_valid_reg;

`ifdef ISSUE_PERF_CNT_EN
  logic        advance;
  logic [15:0] dual_count_reg, split_count_reg;

  assign advance = !flush && !stall_in && (state_reg == ISSUE) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      dual_count_reg  <= '0;
      split_count_reg <= '0;
    end else begin
      if (advance && dual_ok && dual_count_reg != 16'hFFFF)
        dual_count_reg <= dual_count_reg + 16'd1;
      if (advance && split_needed && split_count_reg != 16'hFFFF)
        split_count_reg <= split_count_reg + 16'd1;
    end
  end

  assign dual_count  = dual_count_reg;
  assign split_count = split_count_reg;
`else
  assign dual_count  = 16'h0000;
  assign split_count = 16'h0000;
`endif

endmodule
